sm4_key_schedule_mc: RTL and testbench

//   Multi-slot, parametrised SM4 key schedule. Accepts a 128-bit user key on a valid/ready

---
 rtl/sm4_key_schedule_mc.sv | 180 ++++++++++++++++++
 tb/tb_sm4_key_schedule_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_schedule_mc.sv
// SM4 key schedule with multiple round-key slots.
// Expands a 128-bit user key into 32 round keys, RPC rounds per clock, into a selectable slot.
// Round keys are served through a registered read port in encrypt or decrypt order.
// Supports abort of an expansion and zeroization of all key material.
module sm4_key_schedule_mc #(
   parameter int RPC       = 1,
   parameter int KEY_SLOTS = 2,
   localparam int SLOT_W   = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 key_valid_in,
   output logic                 key_ready_out,
   input  logic [127:0]         key_in,
   input  logic [SLOT_W-1:0]    key_slot_in,
   input  logic                 abort_in,
   input  logic                 zeroize_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [KEY_SLOTS-1:0] slot_valid_out,
   input  logic [SLOT_W-1:0]    rd_slot_in,
   input  logic [4:0]           rd_idx_in,
   input  logic                 rd_decrypt_in,
   output logic [31:0]          rd_key_out
);

   localparam logic [127:0]    FK       = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
   localparam logic [4:0]      RPC_L    = 5'(RPC);
   localparam logic [4:0]      LAST_CNT = 5'(32 - RPC);
   localparam logic [SLOT_W:0] SLOTS_L  = (SLOT_W + 1)'(KEY_SLOTS);
   localparam logic [2047:0]   SBOX     = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXPAND = 1'b1} state_t;

   // Entry x lives at bits [8*(255-x)+7 -: 8], i.e. index {~x, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      logic [31:0] t;
      t = 32'h0;
      for (int b = 0; b < 4; b++) t[31-8*b -: 8] = sbox(a[31-8*b -: 8]);
      return t;
   endfunction

   function automatic logic [31:0] l_prime(input logic [31:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   // CK[i] byte j (j=0 is MSB) = ((4i+j)*7) mod 256, truncation gives the modulo.
   function automatic logic [31:0] ck_word(input logic [4:0] idx);
      logic [7:0]  base;
      logic [31:0] w;
      base = {1'b0, idx, 2'b00};
      w    = 32'h0;
      for (int b = 0; b < 4; b++) w[31-8*b -: 8] = (base + 8'(b)) * 8'd7;
      return w;
   endfunction

   function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
      return ({1'b0, s} < SLOTS_L);
   endfunction

   state_t              r_state;
   state_t              w_state_next;
   logic [31:0]         r_k [4];
   logic [31:0]         r_rk [KEY_SLOTS][32];
   logic [4:0]          r_cnt;
   logic [SLOT_W-1:0]   r_slot;
   logic [KEY_SLOTS-1:0] r_slot_valid;
   logic                r_done;
   logic [31:0]         r_rd_key;
   logic [31:0]         w_rk_beat [RPC];
   logic [31:0]         w_k_next [4];
   logic [4:0]          w_rd_idx;
   logic [31:0]         w_rd_key;
   logic                w_accept;
   logic                w_beat;
   logic                w_last;

   assign w_accept = (r_state == ST_IDLE) && key_valid_in && !zeroize_in;
   assign w_beat   = (r_state == ST_EXPAND) && !abort_in && !zeroize_in;
   assign w_last   = (r_cnt == LAST_CNT);
   assign w_rd_idx = rd_decrypt_in ? (5'd31 - rd_idx_in) : rd_idx_in;
   assign w_rd_key = (slot_ok(rd_slot_in) && r_slot_valid[rd_slot_in]) ?
                     r_rk[rd_slot_in][w_rd_idx] : 32'h0;

   // Unrolled chain of RPC key-schedule rounds starting at round r_cnt.
   always_comb begin
      logic [31:0] k_v [RPC+4];
      for (int m = 0; m < 4; m++) k_v[m] = r_k[m];
      for (int j = 0; j < RPC; j++) begin
         k_v[j+4] = k_v[j] ^ l_prime(tau(k_v[j+1] ^ k_v[j+2] ^ k_v[j+3] ^
                                          ck_word(r_cnt + 5'(j))));
         w_rk_beat[j] = k_v[j+4];
      end
      for (int m = 0; m < 4; m++) w_k_next[m] = k_v[RPC+m];
   end

   // Next-state logic; zeroize overrides everything, abort only matters while expanding.
   always_comb begin
      w_state_next = r_state;
      if (zeroize_in) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (key_valid_in) w_state_next = ST_EXPAND;
               else              w_state_next = ST_IDLE;
            end
            ST_EXPAND: begin
               if (abort_in || w_last) w_state_next = ST_IDLE;
               else                    w_state_next = ST_EXPAND;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Key storage, round counter, slot bookkeeping, done pulse and registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int m = 0; m < 4; m++) r_k[m] <= 32'h0;
         for (int s = 0; s < KEY_SLOTS; s++)
            for (int i = 0; i < 32; i++) r_rk[s][i] <= 32'h0;
         r_cnt        <= 5'd0;
         r_slot       <= '0;
         r_slot_valid <= '0;
         r_done       <= 1'b0;
         r_rd_key     <= 32'h0;
      end else if (zeroize_in) begin
         for (int m = 0; m < 4; m++) r_k[m] <= 32'h0;
         for (int s = 0; s < KEY_SLOTS; s++)
            for (int i = 0; i < 32; i++) r_rk[s][i] <= 32'h0;
         r_cnt        <= 5'd0;
         r_slot       <= '0;
         r_slot_valid <= '0;
         r_done       <= 1'b0;
         r_rd_key     <= 32'h0;
      end else begin
         r_done   <= w_beat && w_last;
         r_rd_key <= w_rd_key;
         if (w_accept) begin
            for (int m = 0; m < 4; m++) r_k[m] <= key_in[127-32*m -: 32] ^ FK[127-32*m -: 32];
            r_slot <= key_slot_in;
            r_cnt  <= 5'd0;
            if (slot_ok(key_slot_in)) r_slot_valid[key_slot_in] <= 1'b0;
         end else if (w_beat) begin
            for (int m = 0; m < 4; m++) r_k[m] <= w_k_next[m];
            r_cnt <= r_cnt + RPC_L;
            if (slot_ok(r_slot)) begin
               for (int j = 0; j < RPC; j++) r_rk[r_slot][r_cnt + 5'(j)] <= w_rk_beat[j];
               if (w_last) r_slot_valid[r_slot] <= 1'b1;
            end
         end
      end
   end

   assign key_ready_out  = (r_state == ST_IDLE) && !zeroize_in;
   assign busy_out       = (r_state == ST_EXPAND);
   assign done_out       = r_done;
   assign slot_valid_out = r_slot_valid;
   assign rd_key_out     = r_rd_key;

endmodule

// File: tb/tb_sm4_key_schedule_mc.sv
// Bench for sm4_key_schedule_mc: four instances (RPC=1,2,4,8) share one stimulus stream and
// are compared against a round-by-round SM4 key schedule model.
module tb_sm4_key_schedule_mc;
   localparam int NDUT = 4;
   localparam logic [127:0] KAT = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [2047:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

   logic          clk = 1'b0;
   logic          reset_n, key_valid_in, abort_in, zeroize_in, rd_decrypt_in;
   logic [127:0]  key_in;
   logic          key_slot_in, rd_slot_in;
   logic [4:0]    rd_idx_in;
   logic          ready_o [NDUT];
   logic          busy_o  [NDUT];
   logic          done_o  [NDUT];
   logic [1:0]    sv_o    [NDUT];
   logic [31:0]   rk_o    [NDUT];

   logic [127:0]  m_key   [2];
   logic          m_valid [2];
   int            checks = 0;
   int            errors = 0;

   typedef struct {
      logic        slot;
      logic [4:0]  idx;
      logic        dec;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sm4_key_schedule_mc #(.RPC(1 << g), .KEY_SLOTS(2)) u_dut (
         .clk(clk), .reset_n(reset_n), .key_valid_in(key_valid_in), .key_ready_out(ready_o[g]),
         .key_in(key_in), .key_slot_in(key_slot_in), .abort_in(abort_in), .zeroize_in(zeroize_in),
         .busy_out(busy_o[g]), .done_out(done_o[g]), .slot_valid_out(sv_o[g]),
         .rd_slot_in(rd_slot_in), .rd_idx_in(rd_idx_in), .rd_decrypt_in(rd_decrypt_in),
         .rd_key_out(rk_o[g]));
   end

   // Reference: full SM4 key expansion from the textbook recurrence, returns rk[idx].
   function automatic logic [31:0] model_rk(input logic [127:0] mk, input int idx);
      logic [31:0]   k [36];
      logic [31:0]   fk [4];
      logic [31:0]   ck, t, s, l;
      logic [2047:0] sb;
      sb = SBOX;
      fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
      for (int m = 0; m < 4; m++) k[m] = mk[127-32*m -: 32] ^ fk[m];
      for (int i = 0; i < 32; i++) begin
         ck = 32'h0;
         for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
         t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
         s = 32'h0;
         for (int j = 0; j < 4; j++) s = (s << 8) | 32'(sb[8*(255 - int'(t[31-8*j -: 8])) +: 8]);
         l = s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
         k[i+4] = k[i] ^ l;
      end
      return k[idx+4];
   endfunction

   function automatic logic [31:0] exp_read(input logic slot, input logic [4:0] idx, input logic dec);
      int i;
      i = dec ? 31 - int'(idx) : int'(idx);
      return m_valid[slot] ? model_rk(m_key[slot], i) : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string name);
      for (int g = 0; g < NDUT; g++)
         chk($sformatf("%s_dut%0d", name, g),
             {27'h0, ready_o[g], busy_o[g], done_o[g], sv_o[g], rk_o[g]},
             {27'h0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
   endtask

   task automatic chk_sv(input string name);
      for (int g = 0; g < NDUT; g++)
         chk($sformatf("%s_dut%0d", name, g), 64'(sv_o[g]), 64'({m_valid[1], m_valid[0]}));
   endtask

   task automatic read_chk(input logic slot, input logic [4:0] idx, input logic dec, input string name);
      logic [31:0] e;
      rd_slot_in = slot; rd_idx_in = idx; rd_decrypt_in = dec;
      tick();
      e = exp_read(slot, idx, dec);
      for (int g = 0; g < NDUT; g++)
         chk($sformatf("%s_dut%0d_s%0d_i%0d_d%0d", name, g, slot, idx, dec), 64'(rk_o[g]), 64'(e));
   endtask

   // Offer a key, then follow all instances to completion checking done/busy/ready/valid timing.
   task automatic load_key(input logic [127:0] key, input logic slot, input logic with_abort);
      int w;
      int bad [NDUT];
      int ndone [NDUT];
      int first [NDUT];
      logic all_rdy;
      w = 0;
      all_rdy = 1'b0;
      while (!all_rdy && w < 50) begin
         all_rdy = ready_o[0] & ready_o[1] & ready_o[2] & ready_o[3];
         if (!all_rdy) begin tick(); w++; end
      end
      chk("ready_wait", 64'(all_rdy), 64'(1'b1));
      key_in = key; key_slot_in = slot; key_valid_in = 1'b1; abort_in = with_abort;
      tick();
      key_valid_in = 1'b0; abort_in = 1'b0;
      m_key[slot] = key; m_valid[slot] = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         chk($sformatf("accept_busy_dut%0d", g), 64'(busy_o[g]), 64'(1'b1));
         bad[g] = 0; ndone[g] = 0; first[g] = 0;
      end
      for (int n = 1; n <= 34; n++) begin
         tick();
         for (int g = 0; g < NDUT; g++) begin
            if (done_o[g] === 1'b1) begin
               ndone[g]++;
               if (first[g] == 0) first[g] = n;
            end
            if (busy_o[g] !== (n < (32 >> g)))       bad[g]++;
            if (ready_o[g] !== (n >= (32 >> g)))     bad[g]++;
            if (sv_o[g][slot] !== (n >= (32 >> g)))  bad[g]++;
         end
      end
      for (int g = 0; g < NDUT; g++) begin
         chk($sformatf("done_latency_dut%0d", g), 64'(first[g]), 64'(32 >> g));
         chk($sformatf("done_pulses_dut%0d", g), 64'(ndone[g]), 64'(1));
         chk($sformatf("handshake_dut%0d", g), 64'(bad[g]), 64'(0));
      end
      m_valid[slot] = 1'b1;
   endtask

   task automatic accept_only(input logic [127:0] key, input logic slot);
      key_in = key; key_slot_in = slot; key_valid_in = 1'b1;
      tick();
      key_valid_in = 1'b0;
      m_key[slot] = key; m_valid[slot] = 1'b0;
   endtask

   task automatic watch_no_done(input string name, input int cycles);
      int nd;
      nd = 0;
      for (int n = 0; n < cycles; n++) begin
         tick();
         for (int g = 0; g < NDUT; g++) if (done_o[g] !== 1'b0) nd++;
      end
      chk(name, 64'(nd), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rkey;
      reset_n = 1'b0; key_valid_in = 1'b0; abort_in = 1'b0; zeroize_in = 1'b0;
      rd_decrypt_in = 1'b0; key_in = 128'h0; key_slot_in = 1'b0; rd_slot_in = 1'b0; rd_idx_in = 5'd0;
      m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_key[0] = 128'h0; m_key[1] = 128'h0;
      tbl[0] = '{1'b0, 5'd0,  1'b0, 32'hF12186F9};
      tbl[1] = '{1'b0, 5'd31, 1'b0, 32'h9124A012};
      tbl[2] = '{1'b0, 5'd0,  1'b1, 32'h9124A012};
      tbl[3] = '{1'b0, 5'd31, 1'b1, 32'hF12186F9};
      tbl[4] = '{1'b1, 5'd0,  1'b0, 32'h00000000};
      tbl[5] = '{1'b1, 5'd31, 1'b1, 32'h00000000};
      tick(); tick();
      chk_reset_vals("reset");
      reset_n = 1'b1;
      tick();
      chk_reset_vals("post_reset");

      // Known-answer key into slot 0, table-driven reads in both orders.
      load_key(KAT, 1'b0, 1'b0);
      chk_sv("kat_sv");
      for (int i = 0; i < 6; i++) begin
         rd_slot_in = tbl[i].slot; rd_idx_in = tbl[i].idx; rd_decrypt_in = tbl[i].dec;
         tick();
         for (int g = 0; g < NDUT; g++)
            chk($sformatf("kat_tbl%0d_dut%0d", i, g), 64'(rk_o[g]), 64'(tbl[i].exp));
      end

      // Read latency: output holds until the next edge after the index changes.
      rd_slot_in = 1'b0; rd_idx_in = 5'd0; rd_decrypt_in = 1'b1;
      tick();
      rd_idx_in = 5'd31;
      #1;
      for (int g = 0; g < NDUT; g++) chk($sformatf("rd_hold_dut%0d", g), 64'(rk_o[g]), 64'(32'h9124A012));
      tick();
      for (int g = 0; g < NDUT; g++) chk($sformatf("rd_next_dut%0d", g), 64'(rk_o[g]), 64'(32'hF12186F9));

      // Random keys and slots; one accept carries abort_in, which must not block it.
      for (int it = 0; it < 6; it++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         load_key(rkey, 1'($urandom_range(0, 1)), (it == 2) ? 1'b1 : 1'b0);
         chk_sv($sformatf("rand%0d_sv", it));
         for (int r = 0; r < 5; r++)
            read_chk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", it));
      end

      // Abort a slot-1 expansion while slot 0 holds the known-answer schedule.
      load_key(KAT, 1'b0, 1'b0);
      accept_only({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      tick(); tick();
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      for (int g = 0; g < NDUT; g++) chk($sformatf("abort_idle_dut%0d", g), 64'(busy_o[g]), 64'(1'b0));
      watch_no_done("abort_no_done", 36);
      chk_sv("abort_sv");
      read_chk(1'b1, 5'd0, 1'b0, "abort_s1");
      read_chk(1'b1, 5'd17, 1'b1, "abort_s1");
      read_chk(1'b0, 5'd0, 1'b0, "abort_s0");
      read_chk(1'b0, 5'd31, 1'b0, "abort_s0");
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      chk_sv("abort_idle_ignored_sv");

      // Zeroize during an expansion with slot 0 valid.
      read_chk(1'b0, 5'd0, 1'b0, "pre_zeroize");
      accept_only({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      tick(); tick();
      zeroize_in = 1'b1;
      tick();
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      for (int g = 0; g < NDUT; g++)
         chk($sformatf("zeroize_dut%0d", g),
             {27'h0, ready_o[g], busy_o[g], done_o[g], sv_o[g], rk_o[g]},
             {27'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0});
      zeroize_in = 1'b0;
      #1;
      for (int g = 0; g < NDUT; g++) chk($sformatf("zeroize_ready_dut%0d", g), 64'(ready_o[g]), 64'(1'b1));
      watch_no_done("zeroize_no_done", 36);
      read_chk(1'b0, 5'd0, 1'b0, "post_zeroize");

      // Asynchronous reset between edges in the middle of an expansion.
      load_key(KAT, 1'b0, 1'b0);
      accept_only({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      tick(); tick(); tick();
      for (int g = 0; g < NDUT; g++) chk($sformatf("pre_rst_busy_dut%0d", g), 64'(busy_o[g]), 64'(1'b1));
      #2;
      reset_n = 1'b0;
      #1;
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      chk_reset_vals("async_reset");
      tick();
      reset_n = 1'b1;
      rkey = {$urandom, $urandom, $urandom, $urandom};
      load_key(rkey, 1'b1, 1'b0);
      chk_sv("after_reset_sv");
      read_chk(1'b1, 5'd0, 1'b0, "after_reset");
      read_chk(1'b1, 5'd31, 1'b0, "after_reset");
      read_chk(1'b1, 5'd9, 1'b1, "after_reset");
      read_chk(1'b0, 5'd0, 1'b0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
